dzcpu_trace_buffer: RTL

//  Synthesizable debug trace capture for the pGB core, sitting beside DZCPU and MMU.

---
 rtl/dzcpu_trace_buffer.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dzcpu_trace_buffer.sv
// ----------------------------------------------------------------------------
// dzcpu_trace_buffer
//
// Debug trace capture for the pGB core. It records DZCPU instruction-end
// events (PC, opcode, flags) and MMU writes (address, data) into a circular
// trace RAM. A UART/JTAG bridge drains the RAM through a simple read handshake
// once capture has stopped.
//
// Capture modes (iMode, latched on iStart):
//   00 off           iStart is ignored
//   01 continuous    ring buffer, runs until iStop
//   10 stop-full     fills the RAM once, then stops
//   11 PC trigger    ring while ARMED, then POST_TRIG more entries after the
//                    CPU event whose PC equals iTrigPc
//
// Entry layout: {type[1:0], addr[15:0], data[7:0], aux[7:0] (, ts)}
//   type 01 CPU {pc, opcode, flags}, type 10 MEM {addr, data, 8'h00}
//
// Ports
//   iClock     system clock, all logic on the rising edge
//   iReset     synchronous, active-low reset
//   iMode      capture mode, sampled on iStart
//   iStart     restart capture: clears pointers, count, overflow, pending
//   iStop      ARMED/CAPTURE -> DONE (iStart wins if both are high)
//   iTrigPc    trigger PC for mode 11
//   iCpuEvt    instruction-end strobe with iCpuPc / iCpuOp / iCpuFlags
//   iMemWe     MMU write strobe with iMemAddr / iMemData
//   iRdReq     read the oldest entry (honoured in IDLE/DONE only)
//   oRdValid   oRdData holds a read entry (one cycle)
//   oRdData    entry read out, one cycle after iRdReq
//   oCount     number of stored entries, 0..DEPTH
//   oState     00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE
//   oOverflow  sticky: an event was dropped or the oldest entry overwritten
//
// Optional feature: define DZCPU_TRACE_TIMESTAMP_EN to append a TS_W-bit
// free-running cycle counter as the LSBs of every entry.
// ----------------------------------------------------------------------------
module dzcpu_trace_buffer #(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int POST_TRIG = 16,
  parameter int TS_W      = 16,
`ifdef DZCPU_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W  = 34 + TS_W
`else
  localparam int ENTRY_W  = 34
`endif
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic [1:0]         iMode,
  input  logic               iStart,
  input  logic               iStop,
  input  logic [15:0]        iTrigPc,
  input  logic               iCpuEvt,
  input  logic [15:0]        iCpuPc,
  input  logic [7:0]         iCpuOp,
  input  logic [7:0]         iCpuFlags,
  input  logic               iMemWe,
  input  logic [15:0]        iMemAddr,
  input  logic [7:0]         iMemData,
  input  logic               iRdReq,
  output logic               oRdValid,
  output logic [ENTRY_W-1:0] oRdData,
  output logic [ADDR_W:0]    oCount,
  output logic [1:0]         oState,
  output logic               oOverflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } stateT;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_FULL = 2'b10;
  localparam logic [1:0] MODE_TRIG = 2'b11;
  localparam logic [1:0] TYPE_CPU  = 2'b01;
  localparam logic [1:0] TYPE_MEM  = 2'b10;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] NEAR_FULL  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] LAST_POST  = (ADDR_W + 1)'(POST_TRIG - 1);

  stateT               state;
  logic [1:0]          capMode;
  logic [ADDR_W-1:0]   wrPtr;
  logic [ADDR_W-1:0]   rdPtr;
  logic [ADDR_W:0]     count;
  logic [ADDR_W:0]     postCount;
  logic                overflow;
  logic                pendValid;
  logic [ENTRY_W-1:0]  pendEntry;
  logic                rdValid;
  logic [ENTRY_W-1:0]  rdData;
  logic [ENTRY_W-1:0]  traceRam [DEPTH];

  logic [ENTRY_W-1:0]  cpuEntry;
  logic [ENTRY_W-1:0]  memEntry;
  logic                capturing;
  logic                startFire;
  logic                wrValid;
  logic [ENTRY_W-1:0]  wrEntry;
  logic                nextPendValid;
  logic [ENTRY_W-1:0]  nextPendEntry;
  logic                dropEvt;
  logic                isFull;
  logic                blockFull;
  logic                doWrite;
  logic                isTrig;
  logic                rdFire;

  // Entry formatting; with timestamps enabled, every entry (including one
  // that gets parked in the pending register) carries its arrival cycle.
`ifdef DZCPU_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] tsCount;

  always_ff @(posedge iClock) begin
    if (!iReset) tsCount <= '0;
    else         tsCount <= tsCount + 1'b1;
  end

  assign cpuEntry = {TYPE_CPU, iCpuPc, iCpuOp, iCpuFlags, tsCount};
  assign memEntry = {TYPE_MEM, iMemAddr, iMemData, 8'h00, tsCount};
`else
  assign cpuEntry = {TYPE_CPU, iCpuPc, iCpuOp, iCpuFlags};
  assign memEntry = {TYPE_MEM, iMemAddr, iMemData, 8'h00};
`endif

  assign capturing = (state == ARMED) || (state == CAPTURE);
  assign startFire = iStart && (iMode != MODE_OFF);
  assign isFull    = (count == FULL_COUNT);

  // Only one RAM write per cycle. Sources are served oldest first: the parked
  // entry, then the CPU event, then the MEM write. The runner-up is parked;
  // a third contender has nowhere to go and is dropped.
  always_comb begin
    wrValid       = 1'b0;
    wrEntry       = '0;
    nextPendValid = pendValid;
    nextPendEntry = pendEntry;
    dropEvt       = 1'b0;
    if (capturing) begin
      nextPendValid = 1'b0;
      if (pendValid) begin
        wrValid = 1'b1;
        wrEntry = pendEntry;
        if (iCpuEvt) begin
          nextPendValid = 1'b1;
          nextPendEntry = cpuEntry;
          dropEvt       = iMemWe;
        end else if (iMemWe) begin
          nextPendValid = 1'b1;
          nextPendEntry = memEntry;
        end
      end else if (iCpuEvt) begin
        wrValid = 1'b1;
        wrEntry = cpuEntry;
        if (iMemWe) begin
          nextPendValid = 1'b1;
          nextPendEntry = memEntry;
        end
      end else if (iMemWe) begin
        wrValid = 1'b1;
        wrEntry = memEntry;
      end
    end
  end

  // Stop-when-full never overwrites; the other modes run as a ring.
  assign blockFull = wrValid && isFull && (capMode == MODE_FULL);
  assign doWrite   = wrValid && !blockFull && iReset && !startFire;
  assign isTrig    = (wrEntry[ENTRY_W-1 -: 2] == TYPE_CPU) &&
                     (wrEntry[ENTRY_W-3 -: 16] == iTrigPc);
  assign rdFire    = iReset && !startFire && iRdReq && (count != '0) &&
                     ((state == IDLE) || (state == DONE));

  // Control: state machine, pointers, occupancy, pending slot and overflow.
  // Reads and writes are never in the same cycle, since they are confined to
  // disjoint states.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state     <= IDLE;
      capMode   <= MODE_OFF;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      postCount <= '0;
      overflow  <= 1'b0;
      pendValid <= 1'b0;
      pendEntry <= '0;
    end else if (startFire) begin
      state     <= (iMode == MODE_TRIG) ? ARMED : CAPTURE;
      capMode   <= iMode;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      postCount <= '0;
      overflow  <= 1'b0;
      pendValid <= 1'b0;
      pendEntry <= '0;
    end else begin
      pendValid <= nextPendValid;
      pendEntry <= nextPendEntry;
      if (dropEvt || blockFull) overflow <= 1'b1;
      if (doWrite) begin
        wrPtr <= wrPtr + 1'b1;
        if (isFull) begin
          rdPtr    <= rdPtr + 1'b1;
          overflow <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
      if (rdFire) begin
        rdPtr <= rdPtr + 1'b1;
        count <= count - 1'b1;
      end
      case (state)
        ARMED: begin
          if (iStop)                   state <= DONE;
          else if (doWrite && isTrig)  state <= CAPTURE;
        end
        CAPTURE: begin
          if (iStop) begin
            state <= DONE;
          end else if (doWrite && (capMode == MODE_FULL)) begin
            if (count == NEAR_FULL) state <= DONE;
          end else if (doWrite && (capMode == MODE_TRIG)) begin
            postCount <= postCount + 1'b1;
            if (postCount == LAST_POST) state <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Trace RAM write port; contents survive reset but become unreachable.
  always_ff @(posedge iClock) begin
    if (doWrite) traceRam[wrPtr] <= wrEntry;
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      rdValid <= 1'b0;
      rdData  <= '0;
    end else begin
      rdValid <= rdFire;
      if (rdFire) rdData <= traceRam[rdPtr];
    end
  end

  assign oRdValid  = rdValid;
  assign oRdData   = rdData;
  assign oCount    = count;
  assign oState    = state;
  assign oOverflow = overflow;

endmodule
